data_memory_stack: RTL and testbench

Parametrised data memory for the core. It holds a word-addressed RAM region and a separate hardware stack region, both in one clock domain. The stack region supports random access through UseStk and also native Push/Pop with an internal stack pointer. It adds overflow/underflow/address-range checking and a registered read path with a valid strobe. It sits between the core datapath and the register file writeback.

---
 rtl/data_memory_stack_if.sv | 38 +++
 rtl/data_memory_stack.sv | 125 ++++++++++++
 tb/tb_data_memory_stack.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/data_memory_stack_if.sv
// Bus between the core datapath and the data memory / hardware stack.
// The master side issues commands; the slave side returns read data and stack status.
interface data_memory_stack_if #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int STK_DEPTH = 100
);
    localparam int SP_W = $clog2(STK_DEPTH + 1);

    logic [DATA_W-1:0] DataIn;
    logic [ADDR_W-1:0] Addr;
    logic              WriteMem;
    logic              ReadMem;
    logic              UseStk;
    logic              Push;
    logic              Pop;

    logic [DATA_W-1:0] DataOut;
    logic              DataValid;
    logic [SP_W-1:0]   StackPointer;
    logic              StkFull;
    logic              StkEmpty;
    logic              StkOverflow;
    logic              StkUnderflow;
    logic              AddrError;

    modport master (
        output DataIn, Addr, WriteMem, ReadMem, UseStk, Push, Pop,
        input  DataOut, DataValid, StackPointer, StkFull, StkEmpty,
               StkOverflow, StkUnderflow, AddrError
    );

    modport slave (
        input  DataIn, Addr, WriteMem, ReadMem, UseStk, Push, Pop,
        output DataOut, DataValid, StackPointer, StkFull, StkEmpty,
               StkOverflow, StkUnderflow, AddrError
    );
endinterface

// File: rtl/data_memory_stack.sv
// Word-addressed data RAM plus a hardware stack region with push/pop, range checking
// and a registered read path that raises a one-cycle valid strobe.
module data_memory_stack #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int RAM_DEPTH = 100,
    parameter int STK_DEPTH = 100
) (
    input  logic               Clock,
    input  logic               ResetN,
    data_memory_stack_if.slave bus
);
    localparam int SP_W   = $clog2(STK_DEPTH + 1);
    localparam int RAM_AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
    localparam int STK_AW = (STK_DEPTH > 1) ? $clog2(STK_DEPTH) : 1;

    logic [DATA_W-1:0] ramMem [RAM_DEPTH];
    logic [DATA_W-1:0] stkMem [STK_DEPTH];

    logic [SP_W-1:0]   stackPtr;
    logic [DATA_W-1:0] dataOutReg;
    logic              dataValidReg;
    logic              overflowReg;
    logic              underflowReg;
    logic              addrErrorReg;

    logic              stkFull;
    logic              stkEmpty;
    logic              stackOp;
    logic              replaceTop;
    logic              doPush;
    logic              pushBlocked;
    logic              doPop;
    logic              popBlocked;
    logic              randWrite;
    logic              randRead;
    logic              inRange;
    logic [RAM_AW-1:0] ramIdx;
    logic [STK_AW-1:0] stkAddrIdx;
    logic [STK_AW-1:0] freeIdx;
    logic [STK_AW-1:0] topIdx;
    logic [DATA_W-1:0] randReadData;

    // Stack commands outrank random access, and a random write outranks a random read.
    // Push together with Pop on an empty stack degenerates into a plain push.
    always_comb begin
        stkFull      = (stackPtr == SP_W'(STK_DEPTH));
        stkEmpty     = (stackPtr == '0);
        stackOp      = bus.Push || bus.Pop;
        replaceTop   = bus.Push && bus.Pop && !stkEmpty;
        doPush       = bus.Push && !replaceTop && !stkFull;
        pushBlocked  = bus.Push && !replaceTop && stkFull;
        doPop        = bus.Pop && !bus.Push && !stkEmpty;
        popBlocked   = bus.Pop && !bus.Push && stkEmpty;
        randWrite    = !stackOp && bus.WriteMem;
        randRead     = !stackOp && !bus.WriteMem && bus.ReadMem;
        inRange      = bus.UseStk ? (bus.Addr < ADDR_W'(STK_DEPTH))
                                  : (bus.Addr < ADDR_W'(RAM_DEPTH));
        ramIdx       = bus.Addr[RAM_AW-1:0];
        stkAddrIdx   = bus.Addr[STK_AW-1:0];
        freeIdx      = STK_AW'(stackPtr);
        topIdx       = STK_AW'(stackPtr - SP_W'(1));
        randReadData = bus.UseStk ? stkMem[stkAddrIdx] : ramMem[ramIdx];
    end

    // Storage is never cleared by reset, so it lives in its own unreset block.
    always_ff @(posedge Clock) begin
        if (replaceTop) begin
            stkMem[topIdx] <= bus.DataIn;
        end else if (doPush) begin
            stkMem[freeIdx] <= bus.DataIn;
        end else if (randWrite && inRange) begin
            if (bus.UseStk) begin
                stkMem[stkAddrIdx] <= bus.DataIn;
            end else begin
                ramMem[ramIdx] <= bus.DataIn;
            end
        end
    end

    // Control and read path. Reads sample the arrays before this edge's write lands,
    // which gives old-data behaviour on a same-address read-during-write.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            stackPtr     <= '0;
            dataOutReg   <= '0;
            dataValidReg <= 1'b0;
            overflowReg  <= 1'b0;
            underflowReg <= 1'b0;
            addrErrorReg <= 1'b0;
        end else begin
            dataValidReg <= 1'b0;
            addrErrorReg <= 1'b0;
            if (replaceTop) begin
                dataOutReg   <= stkMem[topIdx];
                dataValidReg <= 1'b1;
            end else if (doPush) begin
                stackPtr <= stackPtr + SP_W'(1);
            end else if (pushBlocked) begin
                overflowReg <= 1'b1;
            end else if (doPop) begin
                dataOutReg   <= stkMem[topIdx];
                dataValidReg <= 1'b1;
                stackPtr     <= stackPtr - SP_W'(1);
            end else if (popBlocked) begin
                underflowReg <= 1'b1;
            end else if (randWrite) begin
                addrErrorReg <= !inRange;
            end else if (randRead) begin
                dataValidReg <= 1'b1;
                addrErrorReg <= !inRange;
                dataOutReg   <= inRange ? randReadData : '0;
            end
        end
    end

    assign bus.DataOut      = dataOutReg;
    assign bus.DataValid    = dataValidReg;
    assign bus.StackPointer = stackPtr;
    assign bus.StkFull      = stkFull;
    assign bus.StkEmpty     = stkEmpty;
    assign bus.StkOverflow  = overflowReg;
    assign bus.StkUnderflow = underflowReg;
    assign bus.AddrError    = addrErrorReg;
endmodule

// File: tb/tb_data_memory_stack.sv
// Directed and randomized checks of data_memory_stack against an array/counter model
// of the memory rules.
module tb_data_memory_stack;
    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 32;
    localparam int RAM_DEPTH = 100;
    localparam int STK_DEPTH = 100;

    logic Clock  = 1'b0;
    logic ResetN = 1'b0;

    always #5 Clock = ~Clock;

    data_memory_stack_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .STK_DEPTH(STK_DEPTH)) bus ();

    data_memory_stack #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RAM_DEPTH(RAM_DEPTH), .STK_DEPTH(STK_DEPTH)
    ) dut (
        .Clock (Clock),
        .ResetN(ResetN),
        .bus   (bus.slave)
    );

    logic [DATA_W-1:0] refRam [RAM_DEPTH];
    logic [DATA_W-1:0] refStk [STK_DEPTH];
    int                refSp;
    bit                refOvf;
    bit                refUnf;
    bit                expValid;
    bit                expAddrErr;
    logic [DATA_W-1:0] expOut;
    int                checks = 0;
    int                passes = 0;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) passes++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    endtask

    task automatic resetModel();
        refSp      = 0;
        refOvf     = 1'b0;
        refUnf     = 1'b0;
        expValid   = 1'b0;
        expAddrErr = 1'b0;
        expOut     = '0;
    endtask

    task automatic checkAllOutputs(input string tag);
        checkOutput({tag, ".DataOut"},      bus.DataOut,      expOut);
        checkOutput({tag, ".DataValid"},    bus.DataValid,    expValid);
        checkOutput({tag, ".StackPointer"}, bus.StackPointer, refSp);
        checkOutput({tag, ".StkFull"},      bus.StkFull,      refSp == STK_DEPTH);
        checkOutput({tag, ".StkEmpty"},     bus.StkEmpty,     refSp == 0);
        checkOutput({tag, ".StkOverflow"},  bus.StkOverflow,  refOvf);
        checkOutput({tag, ".StkUnderflow"}, bus.StkUnderflow, refUnf);
        checkOutput({tag, ".AddrError"},    bus.AddrError,    expAddrErr);
    endtask

    // Drive one cycle of commands, predict its effect from the memory rules, then check.
    task automatic applyStimulus(input string tag, input bit push, input bit pop,
                                 input bit wr, input bit rd, input bit useStk,
                                 input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
        int depth;
        bus.Push     = push;
        bus.Pop      = pop;
        bus.WriteMem = wr;
        bus.ReadMem  = rd;
        bus.UseStk   = useStk;
        bus.Addr     = addr;
        bus.DataIn   = data;
        expValid   = 1'b0;
        expAddrErr = 1'b0;
        depth = useStk ? STK_DEPTH : RAM_DEPTH;
        if (push && pop && refSp > 0) begin
            expOut = refStk[refSp-1];
            refStk[refSp-1] = data;
            expValid = 1'b1;
        end else if (push) begin
            if (refSp == STK_DEPTH) refOvf = 1'b1;
            else begin
                refStk[refSp] = data;
                refSp++;
            end
        end else if (pop) begin
            if (refSp == 0) refUnf = 1'b1;
            else begin
                refSp--;
                expOut = refStk[refSp];
                expValid = 1'b1;
            end
        end else if (wr) begin
            if (addr >= ADDR_W'(depth)) expAddrErr = 1'b1;
            else if (useStk) refStk[addr] = data;
            else refRam[addr] = data;
        end else if (rd) begin
            expValid = 1'b1;
            if (addr >= ADDR_W'(depth)) begin
                expOut = '0;
                expAddrErr = 1'b1;
            end else begin
                expOut = useStk ? refStk[addr] : refRam[addr];
            end
        end
        @(posedge Clock);
        #1;
        checkAllOutputs(tag);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bus.Push = 1'b0; bus.Pop = 1'b0; bus.WriteMem = 1'b0; bus.ReadMem = 1'b0;
        bus.UseStk = 1'b0; bus.Addr = '0; bus.DataIn = '0;
        resetModel();

        #3;
        checkAllOutputs("reset");
        @(negedge Clock);
        ResetN = 1'b1;
        applyStimulus("idle", 0, 0, 0, 0, 0, '0, '0);

        // Give every word a known value so the model never has to guess.
        for (int i = 0; i < RAM_DEPTH; i++)
            applyStimulus("initRam", 0, 0, 1, 0, 0, ADDR_W'(i), $urandom);
        for (int i = 0; i < STK_DEPTH; i++)
            applyStimulus("initStk", 0, 0, 1, 0, 1, ADDR_W'(i), $urandom);

        applyStimulus("wr5",    0, 0, 1, 0, 0, 5, 32'hDEADBEEF);
        applyStimulus("rd5",    0, 0, 0, 1, 0, 5, '0);
        checkOutput("tp.rd5", bus.DataOut, 32'hDEADBEEF);
        applyStimulus("rdStk5", 0, 0, 0, 1, 1, 5, '0);

        applyStimulus("push11", 1, 0, 0, 0, 0, '0, 32'h11);
        applyStimulus("push22", 1, 0, 0, 0, 0, '0, 32'h22);
        applyStimulus("push33", 1, 0, 0, 0, 0, '0, 32'h33);
        checkOutput("tp.sp3", bus.StackPointer, 3);
        applyStimulus("pop33", 0, 1, 0, 0, 0, '0, '0);
        checkOutput("tp.pop33", bus.DataOut, 32'h33);
        applyStimulus("repl44", 1, 1, 0, 0, 0, '0, 32'h44);
        checkOutput("tp.repl22", bus.DataOut, 32'h22);
        checkOutput("tp.replSp", bus.StackPointer, 2);
        applyStimulus("pop44", 0, 1, 0, 0, 0, '0, '0);
        checkOutput("tp.pop44", bus.DataOut, 32'h44);

        while (refSp < STK_DEPTH)
            applyStimulus("fill", 1, 0, 0, 0, 0, '0, $urandom);
        checkOutput("tp.full", bus.StkFull, 1);
        applyStimulus("overPush", 1, 0, 0, 0, 0, '0, 32'hBAD0);
        checkOutput("tp.ovf", bus.StkOverflow, 1);
        applyStimulus("fullRepl", 1, 1, 0, 0, 0, '0, 32'h5A5A);
        while (refSp > 0)
            applyStimulus("drain", 0, 1, 0, 0, 0, '0, '0);
        applyStimulus("underPop", 0, 1, 0, 0, 0, '0, '0);
        checkOutput("tp.unfValid", bus.DataValid, 0);
        checkOutput("tp.unf", bus.StkUnderflow, 1);
        applyStimulus("emptyPushPop", 1, 1, 0, 0, 0, '0, 32'h77);

        applyStimulus("rdRamOor", 0, 0, 0, 1, 0, ADDR_W'(RAM_DEPTH), '0);
        checkOutput("tp.oorErr", bus.AddrError, 1);
        checkOutput("tp.oorData", bus.DataOut, 0);
        applyStimulus("rdStkOor", 0, 0, 0, 1, 1, ADDR_W'(STK_DEPTH), '0);
        applyStimulus("wrOor",    0, 0, 1, 0, 0, 32'hFFFFFFFF, 32'hCAFEF00D);
        applyStimulus("wrOorStk", 0, 0, 1, 0, 1, 32'hFFFFFFFF, 32'hCAFEF00D);
        for (int i = 0; i < 4; i++)
            applyStimulus("rdLow", 0, 0, 0, 1, 0, ADDR_W'(i), '0);
        applyStimulus("wrRd", 0, 0, 1, 1, 0, 9, 32'h1234);
        applyStimulus("rdAfterWr", 0, 0, 0, 1, 0, 9, '0);

        applyStimulus("pushWr7", 1, 0, 1, 0, 0, 7, 32'h0BADF00D);
        applyStimulus("rd7",     0, 0, 0, 1, 0, 7, '0);
        applyStimulus("stkAbove", 0, 0, 1, 0, 1, 50, 32'h600D);
        applyStimulus("rdAbove",  0, 0, 0, 1, 1, 50, '0);

        applyStimulus("burst0", 1, 0, 0, 0, 0, '0, 32'hA0);
        applyStimulus("burst1", 1, 0, 0, 0, 0, '0, 32'hA1);
        applyStimulus("burst2", 0, 1, 0, 0, 0, '0, '0);
        #2;
        ResetN = 1'b0;
        bus.Push = 1'b0; bus.Pop = 1'b0;
        #1;
        resetModel();
        checkAllOutputs("midReset");
        @(negedge Clock);
        ResetN = 1'b1;
        applyStimulus("postReset", 0, 0, 0, 0, 0, '0, '0);

        for (int n = 0; n < 600; n++) begin
            int op;
            logic [ADDR_W-1:0] addr;
            bit useStk;
            op     = int'($urandom_range(0, 9));
            useStk = bit'($urandom_range(0, 1));
            addr   = ($urandom_range(0, 9) == 0) ? ADDR_W'($urandom)
                                                  : ADDR_W'($urandom_range(0, 104));
            case (op)
                0, 1:    applyStimulus("rndPush", 1, 0, 0, 0, useStk, addr, $urandom);
                2, 3:    applyStimulus("rndPop", 0, 1, 0, 0, useStk, addr, $urandom);
                4:       applyStimulus("rndRepl", 1, 1, 1, 1, useStk, addr, $urandom);
                5, 6:    applyStimulus("rndWr", 0, 0, 1, 0, useStk, addr, $urandom);
                7, 8:    applyStimulus("rndRd", 0, 0, 0, 1, useStk, addr, $urandom);
                default: applyStimulus("rndWrRd", 0, 0, 1, 1, useStk, addr, $urandom);
            endcase
        end

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
